// File: rtl/dkong3_pkg.sv
// ============================================================================
// dkong3_pkg : arbiter state encoding, slot constants, video address helper
// Rev 1.0
// ============================================================================
`default_nettype none

package dkong3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VID_A   = 3'd1,
    ST_VID_D   = 3'd2,
    ST_CPU_A   = 3'd3,
    ST_CPU_D   = 3'd4,
    ST_CPU_REL = 3'd5
  } arb_state_e;

  localparam logic [2:0] FETCH_SLOT      = 3'd6;
  localparam logic [2:0] CPU_CUTOFF_SLOT = 3'd4;

  // Tile-map address: 5-bit row from the vertical count, 5-bit column mirrored under flip.
  function automatic logic [9:0] vid_addr(input logic [4:0] row,
                                          input logic [4:0] col,
                                          input logic       flip);
    return {row, col ^ {5{flip}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dkong3_slot_dec.sv
// ============================================================================
// dkong3_slot_dec : slot-6 entry detect (fetch_start) and CPU slot window decode
// Rev 1.0
// ============================================================================
`default_nettype none

module dkong3_slot_dec
  import dkong3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_h_slot,
  input  logic       i_vid_active,
  output logic       o_fetch_start,
  output logic       o_cpu_slot_ok
);

  logic [2:0] slot_prev_q, slot_prev_d;
  logic       fetch_start_q, fetch_start_d;

  always_comb begin
    slot_prev_d   = i_h_slot;
    fetch_start_d = i_vid_active && (i_h_slot == FETCH_SLOT) && (slot_prev_q != FETCH_SLOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_prev_q   <= 3'd0;
      fetch_start_q <= 1'b0;
    end else begin
      slot_prev_q   <= slot_prev_d;
      fetch_start_q <= fetch_start_d;
    end
  end

  assign o_fetch_start = fetch_start_q;
  // A CPU cycle launched by slot 4 finishes its RAM access before the slot-6 fetch.
  assign o_cpu_slot_ok = !i_vid_active || (i_h_slot <= CPU_CUTOFF_SLOT);

endmodule

`default_nettype wire

// File: rtl/dkong3_vram_arb.sv
// ============================================================================
// dkong3_vram_arb : time-slot arbiter sharing tile VRAM between video and CPU
// Rev 1.0
// ============================================================================
`default_nettype none

module dkong3_vram_arb
  import dkong3_pkg::*;
#(
  parameter logic [7:0] WAIT_LIMIT = 8'd200
) (
  input  logic       I_CLK_24M,
  input  logic       I_RESETn,
  input  logic [9:0] I_H_CNT,
  input  logic [7:0] I_VF_CNT,
  input  logic       I_FLIP,
  input  logic       I_VID_ACTIVE,
  input  logic       I_CPU_REQ,
  input  logic       I_CPU_WE,
  input  logic [9:0] I_CPU_AB,
  input  logic [7:0] I_CPU_DB,
  input  logic [7:0] I_VRAM_DI,
  output logic [9:0] O_VRAM_AB,
  output logic       O_VRAM_CE,
  output logic       O_VRAM_WE,
  output logic [7:0] O_VRAM_DO,
  output logic [7:0] O_CPU_DB,
  output logic       O_WAITn,
  output logic [7:0] O_TILE_CODE,
  output logic       O_TILE_STB,
  output logic       O_STARVE
);

  logic fetch_start;
  logic cpu_slot_ok;

  dkong3_slot_dec u_slot_dec (
    .clk           (I_CLK_24M),
    .rst_n         (I_RESETn),
    .i_h_slot      (I_H_CNT[3:1]),
    .i_vid_active  (I_VID_ACTIVE),
    .o_fetch_start (fetch_start),
    .o_cpu_slot_ok (cpu_slot_ok)
  );

  logic unused_in;
  assign unused_in = ^{I_H_CNT[9], I_H_CNT[0], I_VF_CNT[2:0]};

  arb_state_e state_q, state_d;
  logic       fetch_pend_q, fetch_pend_d;
  logic [9:0] ab_q, ab_d;
  logic [7:0] do_q, do_d;
  logic       ce_q, ce_d;
  logic       we_q, we_d;
  logic       cpu_we_q, cpu_we_d;
  logic [7:0] cpu_db_q, cpu_db_d;
  logic [7:0] tile_code_q, tile_code_d;
  logic       tile_stb_q, tile_stb_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       starve_q, starve_d;

  logic       fetch_go;
  logic       launch_vid;
  logic       waitn;

  assign fetch_go = fetch_start || fetch_pend_q;
  assign waitn    = !(I_CPU_REQ && (state_q != ST_CPU_D) && (state_q != ST_CPU_REL));

  always_comb begin
    state_d      = state_q;
    fetch_pend_d = fetch_pend_q;
    ab_d         = ab_q;
    do_d         = do_q;
    ce_d         = 1'b0;
    we_d         = 1'b0;
    cpu_we_d     = cpu_we_q;
    cpu_db_d     = cpu_db_q;
    tile_code_d  = tile_code_q;
    tile_stb_d   = 1'b0;
    launch_vid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_go) begin
          launch_vid = 1'b1;
        end else if (I_CPU_REQ && cpu_slot_ok) begin
          state_d  = ST_CPU_A;
          ce_d     = 1'b1;
          we_d     = I_CPU_WE;
          cpu_we_d = I_CPU_WE;
          ab_d     = I_CPU_AB;
          do_d     = I_CPU_DB;
        end
      end
      ST_VID_A: state_d = ST_VID_D;
      ST_VID_D: begin
        tile_code_d = I_VRAM_DI;
        tile_stb_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      // A request withdrawn before the data phase abandons the cycle.
      ST_CPU_A: state_d = I_CPU_REQ ? ST_CPU_D : ST_IDLE;
      ST_CPU_D: begin
        if (!cpu_we_q) begin
          cpu_db_d = I_VRAM_DI;
        end
        state_d = ST_CPU_REL;
      end
      ST_CPU_REL: begin
        if (!I_CPU_REQ) begin
          if (fetch_go) begin
            launch_vid = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch_vid) begin
      state_d      = ST_VID_A;
      fetch_pend_d = 1'b0;
      ce_d         = 1'b1;
      ab_d         = vid_addr(I_VF_CNT[7:3], I_H_CNT[8:4], I_FLIP);
    end else if (fetch_start) begin
      fetch_pend_d = 1'b1;
    end

    if (waitn) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q == 8'hFF) begin
      wait_cnt_d = 8'hFF;
    end else begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    starve_d = starve_q || (!waitn && (wait_cnt_d >= WAIT_LIMIT));
  end

  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q      <= ST_IDLE;
      fetch_pend_q <= 1'b0;
      ab_q         <= 10'd0;
      do_q         <= 8'd0;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      cpu_we_q     <= 1'b0;
      cpu_db_q     <= 8'd0;
      tile_code_q  <= 8'd0;
      tile_stb_q   <= 1'b0;
      wait_cnt_q   <= 8'd0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
      ab_q         <= ab_d;
      do_q         <= do_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      cpu_we_q     <= cpu_we_d;
      cpu_db_q     <= cpu_db_d;
      tile_code_q  <= tile_code_d;
      tile_stb_q   <= tile_stb_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign O_VRAM_AB   = ab_q;
  assign O_VRAM_CE   = ce_q;
  assign O_VRAM_WE   = we_q && I_CPU_REQ;
  assign O_VRAM_DO   = do_q;
  assign O_CPU_DB    = cpu_db_q;
  assign O_WAITn     = waitn || !I_RESETn;
  assign O_TILE_CODE = tile_code_q;
  assign O_TILE_STB  = tile_stb_q;
  assign O_STARVE    = starve_q;

endmodule

`default_nettype wire

// File: tb/tb_dkong3_vram_arb.sv
// ============================================================================
// tb_dkong3_vram_arb : directed vectors and corner sequences for the VRAM arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dkong3_vram_arb;

  logic       clk;
  logic       rst_n;
  logic [9:0] h_cnt;
  logic [7:0] vf_cnt;
  logic       flip, vid_active, cpu_req, cpu_we;
  logic [9:0] cpu_ab;
  logic [7:0] cpu_db;
  logic [7:0] ram_q;
  logic [9:0] vram_ab;
  logic       vram_ce, vram_we, waitn, tile_stb, starve;
  logic [7:0] vram_do, cpu_db_out, tile_code;

  logic       h_run;
  logic       pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;
  logic [7:0] mem [0:1023];

  int checks;
  int failures;

  dkong3_vram_arb #(.WAIT_LIMIT(8'd4)) dut (
    .I_CLK_24M    (clk),
    .I_RESETn     (rst_n),
    .I_H_CNT      (h_cnt),
    .I_VF_CNT     (vf_cnt),
    .I_FLIP       (flip),
    .I_VID_ACTIVE (vid_active),
    .I_CPU_REQ    (cpu_req),
    .I_CPU_WE     (cpu_we),
    .I_CPU_AB     (cpu_ab),
    .I_CPU_DB     (cpu_db),
    .I_VRAM_DI    (ram_q),
    .O_VRAM_AB    (vram_ab),
    .O_VRAM_CE    (vram_ce),
    .O_VRAM_WE    (vram_we),
    .O_VRAM_DO    (vram_do),
    .O_CPU_DB     (cpu_db_out),
    .O_WAITn      (waitn),
    .O_TILE_CODE  (tile_code),
    .O_TILE_STB   (tile_stb),
    .O_STARVE     (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: data registered one clock after CE; bench preloads share the port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (vram_ce && vram_we) mem[vram_ab] <= vram_do;
    if (vram_ce) ram_q <= mem[vram_ab];
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (h_run) h_cnt = h_cnt + 10'd1;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"},   {31'd0, vram_ce},    32'd0);
    check({tag, "_we"},   {31'd0, vram_we},    32'd0);
    check({tag, "_ab"},   {22'd0, vram_ab},    32'd0);
    check({tag, "_do"},   {24'd0, vram_do},    32'd0);
    check({tag, "_cpudb"},{24'd0, cpu_db_out}, 32'd0);
    check({tag, "_tile"}, {24'd0, tile_code},  32'd0);
    check({tag, "_stb"},  {31'd0, tile_stb},   32'd0);
    check({tag, "_waitn"},{31'd0, waitn},      32'd1);
    check({tag, "_starve"},{31'd0, starve},    32'd0);
  endtask

  typedef struct packed {
    logic [4:0] h5;
    logic [4:0] vf5;
    logic       flip;
    logic [9:0] exp_ab;
    logic [7:0] tile;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n_ce, n_stb, lowc, wec, drops, vid_at, cpu_at, stb_at;
    logic [9:0] ab_seen;
    logic [7:0] tile_seen, do_seen;
    logic [2:0] cpu_slot;
    logic       granted;

    checks = 0; failures = 0;
    vecs[0] = '{h5: 5'h03, vf5: 5'h02, flip: 1'b0, exp_ab: 10'h043, tile: 8'h11};
    vecs[1] = '{h5: 5'h03, vf5: 5'h02, flip: 1'b1, exp_ab: 10'h05C, tile: 8'h22};
    vecs[2] = '{h5: 5'h1F, vf5: 5'h1F, flip: 1'b0, exp_ab: 10'h3FF, tile: 8'h33};
    vecs[3] = '{h5: 5'h1F, vf5: 5'h1F, flip: 1'b1, exp_ab: 10'h3E0, tile: 8'h44};
    vecs[4] = '{h5: 5'h00, vf5: 5'h00, flip: 1'b1, exp_ab: 10'h01F, tile: 8'h55};
    vecs[5] = '{h5: 5'h0A, vf5: 5'h15, flip: 1'b0, exp_ab: 10'h2AA, tile: 8'h66};

    // Reset with a live request and active display: outputs must sit at reset values.
    rst_n = 1'b0; h_run = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    h_cnt = 10'h00C; vf_cnt = 8'h00; flip = 1'b0; vid_active = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ab = 10'h3FF; cpu_db = 8'hFF;
    step(); step();
    check_reset_outputs("reset");
    cpu_req = 1'b0; vid_active = 1'b0; h_cnt = 10'h000;
    #1; rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) preload(vecs[i].exp_ab, vecs[i].tile);
    preload(10'h044, 8'h77);
    preload(10'h200, 8'h3C);
    preload(10'h155, 8'h00);
    preload(10'h0AA, 8'h00);

    // Table: one video fetch per vector, starting from slot 5 of a cell.
    for (int i = 0; i < 6; i++) begin
      flip = vecs[i].flip; vf_cnt = {vecs[i].vf5, 3'b101};
      h_cnt = {1'b0, vecs[i].h5, 4'b1010}; vid_active = 1'b1; h_run = 1'b1;
      #1;
      n_ce = 0; n_stb = 0; ab_seen = '0; tile_seen = '0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (vram_ce) begin n_ce++; ab_seen = vram_ab; end
        if (tile_stb) begin n_stb++; tile_seen = tile_code; end
      end
      h_run = 1'b0; vid_active = 1'b0;
      check($sformatf("vec%0d_fetch_ab", i), {22'd0, ab_seen}, {22'd0, vecs[i].exp_ab});
      check($sformatf("vec%0d_tile", i), {24'd0, tile_seen}, {24'd0, vecs[i].tile});
      check($sformatf("vec%0d_ce_count", i), n_ce, 1);
      check($sformatf("vec%0d_stb_count", i), n_stb, 1);
    end
    step();

    // Blanking write 8'h5A -> 10'h123 (slot 6 irrelevant while blanked).
    h_cnt = 10'h00C; cpu_we = 1'b1; cpu_ab = 10'h123; cpu_db = 8'h5A; cpu_req = 1'b1;
    #1;
    lowc = 0; wec = 0; ab_seen = '0; do_seen = '0;
    for (int c = 0; c < 8 && !waitn; c++) begin
      lowc++;
      step();
      if (vram_ce && vram_we) begin wec++; ab_seen = vram_ab; do_seen = vram_do; end
    end
    cpu_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (vram_ce && vram_we) wec++;
    end
    check("wr_wait_low_clocks", lowc, 2);
    check("wr_we_clocks", wec, 1);
    check("wr_ab", {22'd0, ab_seen}, 32'h123);
    check("wr_do", {24'd0, do_seen}, 32'h5A);
    check("wr_ram", {24'd0, mem[10'h123]}, 32'h5A);
    check("wr_no_starve", {31'd0, starve}, 32'd0);

    // Read of the same cell with the request held past the release: one access only.
    cpu_we = 1'b0; cpu_req = 1'b1;
    #1;
    n_ce = 0; drops = 0;
    for (int c = 0; c < 8 && !waitn; c++) begin
      step();
      if (vram_ce) n_ce++;
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (vram_ce) n_ce++;
      if (!waitn) drops++;
    end
    cpu_req = 1'b0;
    step(); step();
    check("rd_cpu_db", {24'd0, cpu_db_out}, 32'h5A);
    check("rd_held_ce_count", n_ce, 1);
    check("rd_held_waitn_drops", drops, 0);

    // Request withdrawn while the write is being launched: no RAM write.
    cpu_we = 1'b1; cpu_ab = 10'h0AA; cpu_db = 8'h99; cpu_req = 1'b1;
    #1;
    step();
    check("abort_launch_ce", {31'd0, vram_ce}, 32'd1);
    cpu_req = 1'b0;
    #1;
    check("abort_we_masked", {31'd0, vram_we}, 32'd0);
    step(); step();
    check("abort_ram_untouched", {24'd0, mem[10'h0AA]}, 32'h00);
    check("abort_waitn", {31'd0, waitn}, 32'd1);

    // Active display, read raised at slot 5: fetch first, CPU in the next slot 0..4.
    flip = 1'b0; vf_cnt = 8'h10; h_cnt = 10'h04A; vid_active = 1'b1; h_run = 1'b1;
    cpu_we = 1'b0; cpu_ab = 10'h200; cpu_req = 1'b1;
    #1;
    vid_at = -1; cpu_at = -1; stb_at = -1; cpu_slot = 3'd7; tile_seen = '0; granted = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (vram_ce && vram_ab == 10'h044 && vid_at < 0) vid_at = c;
      if (vram_ce && vram_ab == 10'h200 && cpu_at < 0) begin cpu_at = c; cpu_slot = h_cnt[3:1]; end
      if (tile_stb && stb_at < 0) begin stb_at = c; tile_seen = tile_code; end
      if (waitn) begin granted = 1'b1; break; end
    end
    check("act_grant_in_budget", {31'd0, granted}, 32'd1);
    cpu_req = 1'b0;
    step();
    h_run = 1'b0; vid_active = 1'b0;
    check("act_vid_before_cpu", {31'd0, (vid_at > 0 && cpu_at > vid_at)}, 32'd1);
    check("act_stb_before_cpu", {31'd0, (stb_at > 0 && stb_at < cpu_at)}, 32'd1);
    check("act_tile", {24'd0, tile_seen}, 32'h77);
    check("act_cpu_slot_le4", {31'd0, (cpu_slot <= 3'd4)}, 32'd1);
    check("act_cpu_db", {24'd0, cpu_db_out}, 32'h3C);
    check("act_starve_set", {31'd0, starve}, 32'd1);
    step();

    // Starvation with WAIT_LIMIT=4: slot pinned at 7 in active display.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    h_cnt = 10'h00E; vid_active = 1'b1; cpu_we = 1'b0; cpu_ab = 10'h123; cpu_req = 1'b1;
    #1;
    step(); step(); step();
    check("starve_before_limit", {31'd0, starve}, 32'd0);
    step();
    check("starve_at_limit", {31'd0, starve}, 32'd1);
    h_cnt = 10'h000;
    #1;
    granted = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (waitn) begin granted = 1'b1; break; end
      step();
    end
    check("starve_grant_in_budget", {31'd0, granted}, 32'd1);
    cpu_req = 1'b0;
    step(); step();
    check("starve_sticky", {31'd0, starve}, 32'd1);
    vid_active = 1'b0;

    // Reset pulsed while the write address phase is on the RAM.
    cpu_we = 1'b1; cpu_ab = 10'h155; cpu_db = 8'hA5; cpu_req = 1'b1;
    #1;
    step();
    check("rstmid_write_launched", {31'd0, (vram_ce && vram_we)}, 32'd1);
    #2; rst_n = 1'b0; #1;
    check_reset_outputs("rstmid");
    step(); step();
    check("rstmid_ram_untouched", {24'd0, mem[10'h155]}, 32'h00);
    cpu_req = 1'b0; rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dkong3_vram_arb.md
DKONG3_VRAM_ARB -- requirements
Module: dkong3_vram_arb

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 8'd200: CPU wait-clock count that sets the starvation flag.
REQ-002 SHALL have ports, clock and reset first:
- I_CLK_24M  in  1  sole clock; all state changes on its rising edge.
- I_RESETn  in  1  asynchronous active-low reset.
- I_H_CNT  in  10  horizontal counter.
- I_VF_CNT  in  8  flipped vertical counter.
- I_FLIP  in  1  screen flip.
- I_VID_ACTIVE  in  1  1 = display period; video fetches required.
- I_CPU_REQ  in  1  CPU VRAM cycle request (level, held until O_WAITn rises).
- I_CPU_WE  in  1  1 = write, 0 = read; sampled with request.
- I_CPU_AB  in  10  CPU VRAM address.
- I_CPU_DB  in  8  CPU write data.
- I_VRAM_DI  in  8  RAM read data, valid 1 clock after CE.
- O_VRAM_AB  out  10  RAM address.
- O_VRAM_CE  out  1  RAM enable.
- O_VRAM_WE  out  1  RAM write enable.
- O_VRAM_DO  out  8  RAM write data.
- O_CPU_DB  out  8  latched CPU read data.
- O_WAITn  out  1  0 = stall CPU.
- O_TILE_CODE  out  8  latched tile code.
- O_TILE_STB  out  1  1-clock pulse: O_TILE_CODE updated.
- O_STARVE  out  1  sticky starvation flag.

Function
REQ-003 SHALL decode slot = I_H_CNT[3:1]; fetch_start = 1-clock pulse on the clock after slot becomes 3'b110 while I_VID_ACTIVE=1.
REQ-004 SHALL form video address {I_VF_CNT[7:3], I_H_CNT[8:4] XOR {5{I_FLIP}}}.
REQ-005 SHALL implement FSM states IDLE, VID_A, VID_D, CPU_A, CPU_D, CPU_REL.
REQ-006 IDLE->VID_A on fetch_start, with priority over any CPU request.
REQ-007 IDLE->CPU_A when I_CPU_REQ=1, no fetch_start, and (I_VID_ACTIVE=0 or slot <= 3'd4); CPU_A latches the CPU address, data and WE.
REQ-008 VID_A: CE=1, WE=0, video address; ->VID_D.
REQ-009 VID_D: capture I_VRAM_DI into O_TILE_CODE, pulse O_TILE_STB; ->IDLE.
REQ-010 CPU_A: CE=1, WE=latched WE, address/data from the latches; ->CPU_D.
REQ-011 CPU_D: on a read, capture I_VRAM_DI into O_CPU_DB; O_WAITn=1; ->CPU_REL.
REQ-012 CPU_REL: hold O_WAITn=1 until I_CPU_REQ=0, then ->IDLE, so a held request is never serviced twice.
REQ-013 O_WAITn SHALL be 0 whenever I_CPU_REQ=1 and state is not CPU_D or CPU_REL; 1 otherwise.
REQ-014 O_VRAM_CE=0 and O_VRAM_WE=0 in IDLE, VID_D, CPU_D and CPU_REL.
REQ-015 A fetch_start that occurs during any CPU state SHALL be deferred one clock at most; any CPU access started under REQ-007 completes before slot 6 ends.
REQ-016 Wait counter, 8 bits: increments each clock that O_WAITn=0, clears when O_WAITn=1, saturates at 8'hFF; O_STARVE sets when the count reaches WAIT_LIMIT and stays set until reset.
REQ-017 A request dropped before it is granted SHALL return the FSM to IDLE with no RAM write.

Reset
REQ-018 While I_RESETn=0: state=IDLE, O_VRAM_CE=0, O_VRAM_WE=0, O_VRAM_AB=0, O_VRAM_DO=0, O_CPU_DB=0, O_TILE_CODE=0, O_TILE_STB=0, O_WAITn=1, O_STARVE=0, counters=0.
REQ-019 Reset asserted mid-access SHALL abort the access; no write SHALL complete after reset asserts.

Structure
REQ-020 State encoding and the slot constants (fetch slot 6, CPU cut-off slot 4) SHALL live in shared package dkong3_pkg.
REQ-021 The edge-detect and slot decode SHALL form one sub-module, dkong3_slot_dec; the rest is flat.

Verification
REQ-022 Blanking (I_VID_ACTIVE=0), CPU write 8'h5A to 10'h123 -> CE+WE 1 clock with AB=10'h123, DO=8'h5A; O_WAITn low exactly 2 clocks.
REQ-023 Active display, read request raised at slot 5 -> video fetch first, O_TILE_STB pulse, CPU read serviced at next slot 0..4, O_CPU_DB=RAM contents.
REQ-024 I_FLIP=1, H_CNT[8:4]=5'h03, VF_CNT[7:3]=5'h02 -> fetch AB=10'h05C.
REQ-025 WAIT_LIMIT=8'd4, request held with slot forced to 6/7 -> O_STARVE sets on 4th wait clock and stays set after grant.
REQ-026 Reset pulsed during CPU_A of a write -> no RAM write, all outputs at REQ-018 values.
